// File: rtl/pipeline_pkg.sv
// Shared pipeline types: control word layout, opcode constants and the
// hazard controller state encoding.
package pipeline_pkg;

    typedef struct packed {
        logic       wre;
        logic       wme;
        logic [1:0] wb_sel;
        logic [3:0] alu_op;
    } ctrl_word_t;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LDR = 4'b1001;
    localparam logic [3:0] OP_STR = 4'b1010;
    localparam logic [3:0] OP_BE  = 4'b0100;

    localparam logic [7:0] CTRL_NOP = 8'h00;

    typedef enum logic [1:0] {
        HZ_RUN   = 2'd0,
        HZ_STALL = 2'd1,
        HZ_FLUSH = 2'd2
    } hz_state_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Shift-register scoreboard of in-flight register writes (EX, MEM, WB) and
// the read-after-write compare against the sources of the decode instruction.
module reg_scoreboard
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_W = 4,
    parameter int SB_DEPTH   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_wre_i,
    input  logic [REG_ADDR_W-1:0] issue_rd_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_use_rs1_i,
    input  logic                  id_use_rs2_i,
    output logic                  hazard_o
);

    logic [SB_DEPTH-1:0]   valid_q;
    logic [SB_DEPTH-1:0]   valid_d;
    logic [REG_ADDR_W-1:0] rd_q [SB_DEPTH];
    logic [REG_ADDR_W-1:0] rd_d [SB_DEPTH];

    always_comb begin
        valid_d    = valid_q;
        rd_d       = rd_q;
        valid_d[0] = issue_wre_i;
        rd_d[0]    = issue_rd_i;
        for (int k = 1; k < SB_DEPTH; k++) begin
            valid_d[k] = valid_q[k-1];
            rd_d[k]    = rd_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Register addresses need no reset: they are qualified by valid_q.
    always_ff @(posedge clk) begin
        rd_q <= rd_d;
    end

    // The WB entry is still compared because the register file is written
    // on the edge that ends WB.
    always_comb begin
        hazard_o = 1'b0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            if (valid_q[k] && ((id_use_rs1_i && (rd_q[k] == id_rs1_i)) ||
                               (id_use_rs2_i && (rd_q[k] == id_rs2_i)))) begin
                hazard_o = 1'b1;
            end
        end
        hazard_o = hazard_o & id_valid_i;
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// Decode-stage hazard/stall controller: RAW stalls from the scoreboard, IF/ID
// flush after taken branches, bubble insertion and saturating perf counters.
module hazard_stall_controller
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_W   = 4,
    parameter int SB_DEPTH     = 3,
    parameter int FLUSH_CYCLES = 2,
    parameter int PERF_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [7:0]            control_signals_in,
    input  logic                  ex_branch_taken,
    output logic [7:0]            control_signals_out,
    output logic                  stall_if,
    output logic                  flush_if_id,
    output logic                  bubble,
    output logic [PERF_W-1:0]     stall_count,
    output logic [PERF_W-1:0]     flush_count
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + PERF_W'(1);
    endfunction

    hz_state_t         state_q, state_d;
    logic [CNT_W-1:0]  fcnt_q, fcnt_d;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;
    logic              hazard;
    logic              branch;
    logic              issue_wre;
    ctrl_word_t        ctrl_in;

    assign ctrl_in   = ctrl_word_t'(control_signals_in);
    // A branch pulse seen while reset is held must not show up as a flush.
    assign branch    = ex_branch_taken & rst_n;
    assign issue_wre = ctrl_in.wre & id_valid & ~bubble;

    reg_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W),
        .SB_DEPTH   (SB_DEPTH)
    ) u_sb (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_wre_i  (issue_wre),
        .issue_rd_i   (id_rd),
        .id_valid_i   (id_valid),
        .id_rs1_i     (id_rs1),
        .id_rs2_i     (id_rs2),
        .id_use_rs1_i (id_use_rs1),
        .id_use_rs2_i (id_use_rs2),
        .hazard_o     (hazard)
    );

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        stall_if    = 1'b0;
        flush_if_id = 1'b0;
        bubble      = ~id_valid;
        case (state_q)
            HZ_FLUSH: begin
                flush_if_id = 1'b1;
                bubble      = 1'b1;
                // fcnt_q holds the FLUSH cycles still owed, including this one.
                if (fcnt_q <= CNT_W'(1)) begin
                    state_d = HZ_RUN;
                end else begin
                    fcnt_d = fcnt_q - CNT_W'(1);
                end
            end
            default: begin
                stall_if = hazard;
                bubble   = hazard | ~id_valid;
                state_d  = hazard ? HZ_STALL : HZ_RUN;
            end
        endcase
        if (branch) begin
            stall_if    = 1'b0;
            flush_if_id = 1'b1;
            bubble      = 1'b1;
            fcnt_d      = CNT_W'(FLUSH_CYCLES - 1);
            state_d     = (FLUSH_CYCLES > 1) ? HZ_FLUSH : HZ_RUN;
        end
    end

    always_comb begin
        stall_cnt_d = stall_if    ? sat_inc(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = flush_if_id ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HZ_RUN;
            fcnt_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign control_signals_out = bubble ? CTRL_NOP : control_signals_in;
    assign stall_count         = stall_cnt_q;
    assign flush_count         = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: vector table plus hand-written
// branch, reset and counter-saturation sequences.
module tb_hazard_stall_controller;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [3:0] id_rs1, id_rs2, id_rd;
    logic       id_use_rs1, id_use_rs2;
    logic [7:0] control_signals_in;
    logic       ex_branch_taken;
    logic [7:0] control_signals_out;
    logic       stall_if, flush_if_id, bubble;
    logic [3:0] stall_count, flush_count;

    int checks = 0;
    int errors = 0;

    hazard_stall_controller #(
        .REG_ADDR_W   (4),
        .SB_DEPTH     (3),
        .FLUSH_CYCLES (2),
        .PERF_W       (4)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .id_valid            (id_valid),
        .id_rs1              (id_rs1),
        .id_rs2              (id_rs2),
        .id_use_rs1          (id_use_rs1),
        .id_use_rs2          (id_use_rs2),
        .id_rd               (id_rd),
        .control_signals_in  (control_signals_in),
        .ex_branch_taken     (ex_branch_taken),
        .control_signals_out (control_signals_out),
        .stall_if            (stall_if),
        .flush_if_id         (flush_if_id),
        .bubble              (bubble),
        .stall_count         (stall_count),
        .flush_count         (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [3:0] rs1, rs2;
        logic       u1, u2;
        logic [3:0] rd;
        logic [7:0] ctrl;
        logic       br;
        logic       e_stall, e_flush, e_bub;
        logic [7:0] e_out;
    } vec_t;

    vec_t tbl [11];

    function automatic vec_t mk(logic v, logic [3:0] rs1, logic [3:0] rs2, logic u1,
                                logic u2, logic [3:0] rd, logic [7:0] ctrl, logic br,
                                logic es, logic ef, logic eb, logic [7:0] eo);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.u1 = u1; t.u2 = u2; t.rd = rd;
        t.ctrl = ctrl; t.br = br;
        t.e_stall = es; t.e_flush = ef; t.e_bub = eb; t.e_out = eo;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                         input logic u1, input logic u2, input logic [3:0] rd,
                         input logic [7:0] ctrl, input logic br);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; control_signals_in = ctrl; ex_branch_taken = br;
    endtask

    task automatic chk_outs(input string tag, input logic es, input logic ef,
                            input logic eb, input logic [7:0] eo);
        chk({tag, ".stall_if"}, 32'(stall_if), 32'(es));
        chk({tag, ".flush_if_id"}, 32'(flush_if_id), 32'(ef));
        chk({tag, ".bubble"}, 32'(bubble), 32'(eb));
        chk({tag, ".ctrl_out"}, 32'(control_signals_out), 32'(eo));
    endtask

    // Inputs change on the falling edge; outputs are sampled 2 ns later.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // load-use, independent adds, store then reader, invalid slot with wre
        tbl[0]  = mk(1, 0, 0, 0, 0, 3,  8'h80, 0, 0, 0, 0, 8'h80);
        tbl[1]  = mk(1, 3, 0, 1, 0, 4,  8'h81, 0, 1, 0, 1, 8'h00);
        tbl[2]  = mk(1, 3, 0, 1, 0, 4,  8'h81, 0, 1, 0, 1, 8'h00);
        tbl[3]  = mk(1, 3, 0, 1, 0, 4,  8'h81, 0, 1, 0, 1, 8'h00);
        tbl[4]  = mk(1, 3, 0, 1, 0, 4,  8'h81, 0, 0, 0, 0, 8'h81);
        tbl[5]  = mk(1, 5, 6, 1, 1, 1,  8'h81, 0, 0, 0, 0, 8'h81);
        tbl[6]  = mk(1, 7, 8, 1, 1, 2,  8'h81, 0, 0, 0, 0, 8'h81);
        tbl[7]  = mk(1, 0, 0, 0, 0, 9,  8'h40, 0, 0, 0, 0, 8'h40);
        tbl[8]  = mk(1, 9, 0, 1, 0, 10, 8'h81, 0, 0, 0, 0, 8'h81);
        tbl[9]  = mk(0, 0, 0, 0, 0, 11, 8'h80, 0, 0, 0, 1, 8'h00);
        tbl[10] = mk(1, 11, 0, 1, 0, 12, 8'h01, 0, 0, 0, 0, 8'h01);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 8'h00, 0);
        #12;
        chk_outs("reset_idle", 0, 0, 1, 8'h00);
        chk("reset.stall_count", 32'(stall_count), 0);
        chk("reset.flush_count", 32'(flush_count), 0);
        drive(1, 0, 0, 0, 0, 0, 8'h81, 0);
        #1;
        chk_outs("reset_valid", 0, 0, 0, 8'h81);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 8'h00, 0);
        rst_n = 1'b1;
        cycle();

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2,
                  tbl[i].rd, tbl[i].ctrl, tbl[i].br);
            #2;
            chk_outs($sformatf("vec%0d", i), tbl[i].e_stall, tbl[i].e_flush,
                     tbl[i].e_bub, tbl[i].e_out);
            cycle();
        end
        chk("table.stall_count", 32'(stall_count), 3);
        chk("table.flush_count", 32'(flush_count), 0);

        // Taken branch: pulse cycle plus one FLUSH cycle
        drive(1, 0, 0, 0, 0, 13, 8'h81, 1); #2; chk_outs("br_pulse", 0, 1, 1, 8'h00); cycle();
        drive(1, 0, 0, 0, 0, 13, 8'h81, 0); #2; chk_outs("br_flush", 0, 1, 1, 8'h00); cycle();
        #2; chk_outs("br_run", 0, 0, 0, 8'h81); cycle();
        chk("br.flush_count", 32'(flush_count), 2);

        // Branch colliding with an active stall
        drive(1, 0, 0, 0, 0, 5, 8'h81, 0);  #2; chk_outs("col_prod", 0, 0, 0, 8'h81); cycle();
        drive(1, 5, 0, 1, 0, 14, 8'h81, 0); #2; chk_outs("col_stall", 1, 0, 1, 8'h00); cycle();
        ex_branch_taken = 1'b1;             #2; chk_outs("col_branch", 0, 1, 1, 8'h00); cycle();
        drive(0, 0, 0, 0, 0, 0, 8'h00, 0);  #2; chk_outs("col_flush", 0, 1, 1, 8'h00);
        chk("col.sb_entry0_valid", 32'(dut.u_sb.valid_q[0]), 0);
        cycle(); cycle(); cycle();
        chk("col.stall_count", 32'(stall_count), 4);
        chk("col.flush_count", 32'(flush_count), 4);

        // Reset asserted in the middle of FLUSH
        drive(1, 0, 0, 0, 0, 6, 8'h80, 0); #2; chk_outs("rst_prod", 0, 0, 0, 8'h80); cycle();
        drive(0, 0, 0, 0, 0, 0, 8'h00, 1); cycle();
        ex_branch_taken = 1'b0; #2; chk_outs("rst_inflush", 0, 1, 1, 8'h00);
        rst_n = 1'b0; #1;
        chk_outs("rst_async", 0, 0, 1, 8'h00);
        chk("rst_async.stall_count", 32'(stall_count), 0);
        chk("rst_async.flush_count", 32'(flush_count), 0);
        cycle();
        rst_n = 1'b1;
        drive(1, 6, 0, 1, 0, 0, 8'h81, 0); #2; chk_outs("rst_release", 0, 0, 0, 8'h81); cycle();

        // Repeated load-use rounds of 3 stalls each drive stall_count into saturation
        for (int r = 0; r < 6; r++) begin
            drive(1, 0, 0, 0, 0, 7, 8'h80, 0); cycle();
            drive(1, 7, 0, 1, 0, 8, 8'h01, 0);
            cycle(); cycle(); cycle(); cycle();
            if (r == 3) chk("sat.stall_count_12", 32'(stall_count), 12);
        end
        chk("sat.stall_count_15", 32'(stall_count), 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
